addr4u_share_ctrl: RTL and testbench

- Arbiter and sequencer that shares one combinational 4-bit unsigned adder (5-bit result) between NREQ requesters.
- Adds time-redundant fault checking. Each operation runs twice: first with operands as given, then with operands swapped. The two results are compared.
- On a mismatch the pair is re-executed, up to MAX_RETRY times. If every attempt mismatches, the response carries an error flag.
- Sits between requester logic and an instance of the fault-resilient 4-bit adder.

---
 rtl/addr4u_share_ctrl.sv | 131 +++++++++++++
 tb/tb_addr4u_share_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/addr4u_share_ctrl.sv
// Round-robin arbiter and sequencer sharing one 4-bit adder between NREQ requesters.
// Every operation runs twice with swapped operands; mismatching pairs are retried.
module addr4u_share_ctrl #(
  parameter int NREQ      = 4,
  parameter int ID_W      = 2,
  parameter int MAX_RETRY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] req_a,
  input  logic [4*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic [3:0]        adder_a,
  output logic [3:0]        adder_b,
  input  logic [4:0]        adder_o,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [ID_W-1:0]   rsp_id,
  output logic [4:0]        rsp_sum,
  output logic              rsp_err,
  output logic              busy
);

  localparam int RC_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {IDLE, EXEC1, EXEC2, CHECK, RESP} state_t;

  state_t          state, state_next;
  logic [ID_W-1:0] ptr, win, ptr_next;
  logic [RC_W-1:0] retry;
  logic [3:0]      opa, opb;
  logic [4:0]      r1, r2;
  logic            accept, mismatch, retry_go;

  // First set request bit at or above the pointer, wrapping modulo NREQ.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                              input logic [ID_W-1:0] p);
    logic [ID_W-1:0] sel;
    logic            hit;
    int              idx;
    sel = '0;
    hit = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(p) + k) % NREQ;
      if (!hit && r[ID_W'(idx)]) begin
        hit = 1'b1;
        sel = ID_W'(idx);
      end
    end
    return sel;
  endfunction

  assign win      = rr_pick(req, ptr);
  assign ptr_next = (win == ID_W'(NREQ - 1)) ? '0 : win + 1'b1;
  assign mismatch = (r1 != r2);
  assign retry_go = mismatch && (int'(retry) < MAX_RETRY);

  always_comb begin
    state_next = state;
    adder_a    = '0;
    adder_b    = '0;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (|req) begin
          accept     = 1'b1;
          state_next = EXEC1;
        end
      end
      EXEC1: begin
        adder_a    = opa;
        adder_b    = opb;
        state_next = EXEC2;
      end
      EXEC2: begin
        adder_a    = opb;
        adder_b    = opa;
        state_next = CHECK;
      end
      CHECK:   state_next = retry_go ? EXEC1 : RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      retry     <= '0;
      gnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      gnt   <= '0;
      if (accept) begin
        gnt    <= NREQ'(1) << win;
        ptr    <= ptr_next;
        retry  <= '0;
        rsp_id <= win;
      end
      if (state == CHECK) begin
        if (retry_go) begin
          retry <= retry + 1'b1;
        end else begin
          rsp_valid <= 1'b1;
          rsp_sum   <= r1;
          rsp_err   <= mismatch;
        end
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

  // Operand and result capture: plain data, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      opa <= req_a[{win, 2'b00} +: 4];
      opb <= req_b[{win, 2'b00} +: 4];
    end
    if (state == EXEC1) r1 <= adder_o;
    if (state == EXEC2) r2 <= adder_o;
  end

endmodule

// File: tb/tb_addr4u_share_ctrl.sv
// Scoreboard bench for addr4u_share_ctrl with a fault-injecting adder model.
module tb_addr4u_share_ctrl;

  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam int MAXR = 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_a, req_b;
  logic [NREQ-1:0]   gnt;
  logic [3:0]        adder_a, adder_b;
  logic [4:0]        adder_o;
  logic              rsp_valid, rsp_ready, rsp_err, busy;
  logic [ID_W-1:0]   rsp_id;
  logic [4:0]        rsp_sum;

  addr4u_share_ctrl #(.NREQ(NREQ), .ID_W(ID_W), .MAX_RETRY(MAXR)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b), .gnt(gnt),
    .adder_a(adder_a), .adder_b(adder_b), .adder_o(adder_o),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_err(rsp_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Adder: mode 1 flips bit 0 on the first swapped pair (fb,fa); mode 2 whenever adder_a==3.
  logic [1:0] fmode = 2'd0;
  logic [3:0] fa = 4'd0, fb = 4'd0;
  logic       seen_swap = 1'b0;
  logic       flip;
  assign flip = (fmode == 2'd2 && adder_a == 4'd3) ||
                (fmode == 2'd1 && !seen_swap && adder_a == fb && adder_b == fa);
  assign adder_o = ({1'b0, adder_a} + {1'b0, adder_b}) ^ {4'b0, flip};
  always @(posedge clk) begin
    if (fmode != 2'd1) seen_swap <= 1'b0;
    else if (adder_a == fb && adder_b == fa) seen_swap <= 1'b1;
  end

  typedef struct {
    int id;
    int sum;
    int err;
    int due;
  } exp_t;

  exp_t            q[$];
  exp_t            cur;
  logic            cur_act = 1'b0;
  int              cyc = 0;
  int              m_ptr = 0;
  int              m_due = 0;
  logic            m_busy = 1'b0;
  logic            rst_seen = 1'b0;
  logic [NREQ-1:0] exp_gnt = '0;
  int              checks = 0;
  int              errors = 0;

  // Behavioural result of an operation: attempts repeat until the pair agrees or retries run out.
  function automatic exp_t predict(input int id, input int a, input int b,
                                   input int mode, input int t);
    exp_t e;
    int s, r1, r2, att;
    s = a + b; r1 = s; r2 = s; att = 0;
    for (int k = 0; k <= MAXR; k++) begin
      att = k;
      r1 = s ^ ((mode == 2 && a == 3) ? 1 : 0);
      r2 = s ^ (((mode == 2 && b == 3) || (mode == 1 && k == 0)) ? 1 : 0);
      if (r1 == r2) break;
    end
    e.id  = id;
    e.sum = r1;
    e.err = (r1 != r2) ? 1 : 0;
    e.due = t + 4 + 3 * att;
    return e;
  endfunction

  // Reference model, updated at each rising edge from the stimulus values.
  always @(posedge clk) begin
    int w;
    exp_gnt  = '0;
    rst_seen = 1'b0;
    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      q.delete();
      rst_seen = 1'b1;
    end else if (!m_busy && req != '0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
      q.push_back(predict(w, int'(req_a[w*4 +: 4]), int'(req_b[w*4 +: 4]), int'(fmode), cyc));
      m_due  = q[$].due;
      m_busy = 1'b1;
      exp_gnt[w] = 1'b1;
      m_ptr  = (w + 1) % NREQ;
    end else if (m_busy && cyc >= m_due && rsp_ready) begin
      m_busy = 1'b0;
    end
    cyc++;
  end

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, expv);
    end
  endtask

  // Monitor: compares DUT outputs against the model on the falling edge.
  always @(negedge clk) begin
    chk("gnt", int'(gnt), int'(exp_gnt));
    chk("busy", int'(busy), int'(m_busy));
    chk("rsp_valid", int'(rsp_valid), (m_busy && cyc >= m_due) ? 1 : 0);
    if (!m_busy) begin
      chk("adder_a_idle", int'(adder_a), 0);
      chk("adder_b_idle", int'(adder_b), 0);
    end
    if (rst_seen) begin
      cur_act = 1'b0;
      chk("rst_rsp_id", int'(rsp_id), 0);
      chk("rst_rsp_sum", int'(rsp_sum), 0);
      chk("rst_rsp_err", int'(rsp_err), 0);
    end
    if (rsp_valid) begin
      if (!cur_act && q.size() > 0) begin
        cur = q.pop_front();
        cur_act = 1'b1;
        chk("rsp_latency", cyc, cur.due);
      end
      if (cur_act) begin
        chk("rsp_id", int'(rsp_id), cur.id);
        chk("rsp_sum", int'(rsp_sum), cur.sum);
        chk("rsp_err", int'(rsp_err), cur.err);
      end
    end else begin
      cur_act = 1'b0;
    end
  end

  logic [NREQ-1:0] keep = '0;
  int              ngrants = 0;
  int              nticks = 0;

  task automatic raise(input int i, input logic [3:0] a, input logic [3:0] b);
    req_a[i*4 +: 4] = a;
    req_b[i*4 +: 4] = b;
    req[i] = 1'b1;
  endtask

  // One clock: requesters drop (or renew, if kept) their request once granted.
  task automatic tick();
    @(posedge clk);
    #1;
    nticks++;
    if (nticks > 20000) begin
      $display("FAIL tick_budget: got %0d cycles, expected under 20000", nticks);
      $fatal(1, "cycle budget exhausted");
    end
    if (gnt != '0) ngrants++;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        if (keep[i]) begin
          req_a[i*4 +: 4] = 4'($urandom_range(0, 15));
          req_b[i*4 +: 4] = 4'($urandom_range(0, 15));
        end else begin
          req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while ((m_busy || req != '0) && n < 400);
    if (n >= 400) begin
      $display("FAIL wait_idle: got %0d cycles busy, expected under 400", n);
      $fatal(1, "wait_idle bound expired");
    end
  endtask

  task automatic rand_phase(input int ncyc, input logic [1:0] mode);
    fmode = mode;
    for (int c = 0; c < ncyc; c++) begin
      rsp_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0)
          raise(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        else if (req[i] && $urandom_range(0, 15) == 0)
          req[i] = 1'b0;
      end
      tick();
    end
    rsp_ready = 1'b1;
    wait_idle();
    fmode = 2'd0;
  endtask

  initial begin
    int n;
    rst = 1'b1; req = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Healthy single request: 9+7.
    raise(0, 4'd9, 4'd7);
    wait_idle();

    // One transient fault on the first swapped execution: 6+5.
    fa = 4'd6; fb = 4'd5; fmode = 2'd1;
    raise(2, 4'd6, 4'd5);
    wait_idle();
    fmode = 2'd0;

    // Persistent fault when adder_a==3: retries exhaust with error.
    fmode = 2'd2;
    raise(1, 4'd3, 4'd5);
    wait_idle();
    fmode = 2'd0;

    // Back-pressure: response held while another request is pending.
    rsp_ready = 1'b0;
    raise(3, 4'd12, 4'd10);
    raise(1, 4'd4, 4'd2);
    n = 0;
    while (!rsp_valid && n < 50) begin
      tick();
      n++;
    end
    repeat (5) tick();
    rsp_ready = 1'b1;
    wait_idle();

    // Reset during EXEC2 aborts the operation and clears the pointer.
    raise(1, 4'd15, 4'd15);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // All four held high: grants rotate 0,1,2,3,0 five cycles apart.
    keep = '1;
    for (int i = 0; i < NREQ; i++) raise(i, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    ngrants = 0;
    n = 0;
    while (ngrants < 5 && n < 100) begin
      tick();
      n++;
    end
    keep = '0;
    wait_idle();

    rand_phase(400, 2'd0);
    rand_phase(400, 2'd2);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
